timer_dev: RTL and testbench
============================

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 addr  input  2  register select, CPU byte address bits [3:2]: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write enable from the CPU bridge, sampled on the rising edge of clk.
REQ-006 wdata  input  32  write data.
REQ-007 rdata  output  32  read data, combinational from addr.
REQ-008 irq  output  1  interrupt request to the CPU, equal to irq_flag AND CTRL.IM.

Function
REQ-009 CTRL SHALL be laid out as: bit0 EN (enable), bits2:1 MODE (0=one-shot, 1=auto-reload, 2/3 treated as 0), bit3 IM (interrupt mask), bits31:4 reading 0.
REQ-010 A write SHALL take effect at the clock edge where we=1; a write to COUNT or the reserved address SHALL be ignored.
REQ-011 rdata SHALL return CTRL (zero-extended), PRESET, or COUNT for addr 0/1/2, and 0 for addr 3.
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, CNT, INT.
REQ-013 IDLE: if EN=1, go to LOAD on the next edge; otherwise hold, with COUNT unchanged.
REQ-014 LOAD: COUNT <= PRESET, then go to CNT.
REQ-015 CNT: if EN=0, go to IDLE with COUNT held; else if COUNT=0, go to INT and set irq_flag; else COUNT <= COUNT-1.
REQ-016 INT, MODE=0: clear EN, go to IDLE, keep irq_flag set.
REQ-017 INT, MODE=1: go to IDLE with EN still 1, and clear irq_flag on leaving INT, so irq pulses for exactly 1 cycle.
REQ-018 irq_flag SHALL be cleared by any write to CTRL or PRESET.
REQ-019 Latency: with PRESET=P, irq SHALL rise at the (P+3)th edge after the edge that writes EN=1; in MODE=1 the irq period SHALL be P+4 cycles.
REQ-020 PRESET=0 SHALL reach INT 3 edges after the enable write.
REQ-021 A PRESET write during CNT SHALL NOT alter the running COUNT; the new value applies at the next LOAD.
REQ-022 If a CPU CTRL write and the INT-state EN clear fall on the same edge, the CPU write value SHALL win.
REQ-023 Clearing EN mid-count SHALL freeze COUNT; re-enabling SHALL restart from LOAD, not resume.
REQ-024 COUNT SHALL never wrap: the decrement is only performed when COUNT is nonzero.

Reset
REQ-025 While reset=1, the block SHALL asynchronously force: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, irq=0.
REQ-026 A reset asserted in any state, including mid-count, SHALL abort the count with no residual irq after release.
REQ-027 The first edge after reset release SHALL behave as IDLE with EN=0.

Configuration
REQ-028 With macro TIMER_RELOAD_EN defined, MODE=1 auto-reload SHALL behave per REQ-017.
REQ-029 With TIMER_RELOAD_EN undefined, MODE bits SHALL be stored as 0 and read back as 0, and every count SHALL behave as one-shot (REQ-016).

Verification
REQ-030 Reset release, then read addr 0/1/2/3 -> all return 0, irq=0.
REQ-031 Write PRESET=5, then CTRL=0x9 (EN=1, IM=1, MODE=0) -> irq rises 8 edges after the CTRL write and stays high; CTRL reads 0x8; a write to CTRL drops irq on the next edge.
REQ-032 With TIMER_RELOAD_EN, write PRESET=2 and CTRL=0xB -> irq 1-cycle pulses every 6 cycles, and COUNT reads 2,1,0 in each period.
REQ-033 Write PRESET=10 and CTRL=0x9; after 4 edges write CTRL=0x8 -> COUNT frozen at 8 and no irq; rewriting CTRL=0x9 -> irq 13 edges later.
REQ-034 Write PRESET=3 and CTRL=0x1 (IM=0) -> irq_flag set but irq stays 0; writing CTRL=0x8 -> irq stays 0 because the flag is cleared.
REQ-035 Assert reset 2 cycles into CNT with PRESET=7 -> all registers read 0 and irq stays 0 for 20 cycles after release.

Source files
------------

// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - CPU register bus bundle for timer_dev
interface timer_dev_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - down-counting timer with irq; auto-reload mode under `TIMER_RELOAD_EN
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CNT  = 2'd2;
  localparam logic [1:0] S_INT  = 2'd3;

  logic [1:0]  state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        auto_reload;
  logic        cnt_done;

  assign ctrl_wr     = bus.we && (bus.addr == 2'd0);
  assign preset_wr   = bus.we && (bus.addr == 2'd1);
  // MODE encodings 2 and 3 fall back to one-shot
  assign auto_reload = (mode == 2'd1);
  assign cnt_done    = (state == S_CNT) && en && (count == 32'd0);

  // CTRL register; a CPU write beats the one-shot EN clear on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en   <= 1'b0;
      mode <= 2'd0;
      im   <= 1'b0;
    end else if (ctrl_wr) begin
      en   <= bus.wdata[0];
`ifdef TIMER_RELOAD_EN
      mode <= bus.wdata[2:1];
`else
      mode <= 2'd0;
`endif
      im   <= bus.wdata[3];
    end else if ((state == S_INT) && !auto_reload) begin
      en <= 1'b0;
    end
  end

  // PRESET register; only sampled by the FSM in LOAD
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset <= 32'd0;
    end else if (preset_wr) begin
      preset <= bus.wdata;
    end
  end

  // Counter FSM: IDLE -> LOAD -> CNT (down to zero) -> INT -> IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      count <= 32'd0;
    end else begin
      case (state)
        S_IDLE: if (en) state <= S_LOAD;
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          if (!en)
            state <= S_IDLE;
          else if (count == 32'd0)
            state <= S_INT;
          else
            count <= count - 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Interrupt flag: set on terminal count, cleared by register writes or on auto-reload exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (ctrl_wr || preset_wr) begin
      irq_flag <= 1'b0;
    end else if (cnt_done) begin
      irq_flag <= 1'b1;
    end else if ((state == S_INT) && auto_reload) begin
      irq_flag <= 1'b0;
    end
  end

  // Register read mux
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, im, mode, en};
      2'd1:    bus.rdata = preset;
      2'd2:    bus.rdata = count;
      default: bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = irq_flag & im;

endmodule

// File: tb/tb_timer_dev.sv
// tb/tb_timer_dev.sv - self-checking bench for timer_dev
module tb_timer_dev;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  timer_dev_if bus();

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a run is tracked as "edges since leaving idle" (m_r);
  // COUNT follows arithmetically from the preset snapshot taken at run edge 1.
  logic        m_en;
  logic [1:0]  m_mode;
  logic        m_im;
  logic [31:0] m_preset;
  logic [31:0] m_count;
  logic        m_flag;
  longint      m_r;
  longint      m_snap;

  always @(posedge clk or posedge reset) begin : model
    logic        n_en, n_im, n_flag;
    logic [1:0]  n_mode;
    logic [31:0] n_pre, n_cnt;
    longint      n_r, n_snap;
    if (reset) begin
      m_en <= 1'b0; m_mode <= 2'd0; m_im <= 1'b0; m_preset <= 32'd0;
      m_count <= 32'd0; m_flag <= 1'b0; m_r <= 0; m_snap <= 0;
    end else begin
      n_en = m_en; n_mode = m_mode; n_im = m_im; n_pre = m_preset;
      n_cnt = m_count; n_flag = m_flag; n_r = m_r; n_snap = m_snap;
      if (m_r == 0) begin
        if (m_en) n_r = 1;
      end else if (m_r == 1) begin
        n_snap = longint'(m_preset);
        n_cnt  = m_preset;
        n_r    = 2;
      end else if (m_r == m_snap + 3) begin
        n_r = 0;
        if (m_mode == 2'd1) n_flag = 1'b0;
        else                n_en   = 1'b0;
      end else if (!m_en) begin
        n_r = 0;
      end else begin
        n_r = m_r + 1;
        if (n_r == m_snap + 3) n_flag = 1'b1;
        else                   n_cnt  = 32'(m_snap - (n_r - 2));
      end
      if (bus.we && bus.addr == 2'd0) begin
        n_en = bus.wdata[0];
`ifdef TIMER_RELOAD_EN
        n_mode = bus.wdata[2:1];
`else
        n_mode = 2'd0;
`endif
        n_im   = bus.wdata[3];
        n_flag = 1'b0;
      end
      if (bus.we && bus.addr == 2'd1) begin
        n_pre  = bus.wdata;
        n_flag = 1'b0;
      end
      m_en <= n_en; m_mode <= n_mode; m_im <= n_im; m_preset <= n_pre;
      m_count <= n_cnt; m_flag <= n_flag; m_r <= n_r; m_snap <= n_snap;
    end
  end

  // Continuous compare of rdata and irq against the model, away from the active edge
  always @(negedge clk) begin : compare
    logic [31:0] exp_rd;
    case (bus.addr)
      2'd0:    exp_rd = {28'd0, m_im, m_mode, m_en};
      2'd1:    exp_rd = m_preset;
      2'd2:    exp_rd = m_count;
      default: exp_rd = 32'd0;
    endcase
    n_checks++;
    if (bus.rdata !== exp_rd) begin
      n_fails++;
      $display("FAIL model_rdata t=%0t addr=%0d actual=%0h expected=%0h", $time, bus.addr, bus.rdata, exp_rd);
    end
    n_checks++;
    if (bus.irq !== (m_flag & m_im)) begin
      n_fails++;
      $display("FAIL model_irq t=%0t actual=%0b expected=%0b", $time, bus.irq, m_flag & m_im);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.we = 1'b1;
    cyc();
    bus.we = 1'b0; bus.addr = 2'd2;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus.addr = a;
    #1;
    chk(name, bus.rdata, exp);
    bus.addr = 2'd2;
  endtask

  // Runs n edges after a start write and expects irq high exactly at edge rise and after
  task automatic irq_rise(input int n, input int rise, input string name);
    for (int k = 1; k <= n; k++) begin
      cyc();
      chk(name, {31'd0, bus.irq}, (k >= rise) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    bus.addr = 2'd2; bus.we = 1'b0; bus.wdata = 32'd0;
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    cyc();

    // Reset state
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_preset");
    rd(2'd2, 32'd0, "rst_count");
    rd(2'd3, 32'd0, "rst_reserved");
    chk("rst_irq", {31'd0, bus.irq}, 32'd0);

    // One-shot, PRESET=5: irq at edge 8, sticky, CTRL reads 0x8, cleared by CTRL write
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    irq_rise(12, 8, "oneshot_p5_irq");
    rd(2'd0, 32'h8, "oneshot_ctrl_after");
    rd(2'd2, 32'd0, "oneshot_count_after");
    wr(2'd0, 32'h8);
    chk("oneshot_irq_drop", {31'd0, bus.irq}, 32'd0);

    // Freeze mid-count, then restart from LOAD
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    repeat (3) cyc();
    wr(2'd0, 32'h8);
    repeat (4) cyc();
    rd(2'd2, 32'd8, "freeze_count");
    chk("freeze_irq", {31'd0, bus.irq}, 32'd0);
    wr(2'd0, 32'h9);
    irq_rise(14, 13, "restart_p10_irq");
    wr(2'd0, 32'h0);

    // IM=0: flag set silently, then unmasking after a clearing write gives no irq
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    irq_rise(8, 99, "masked_irq");
    wr(2'd0, 32'h8);
    irq_rise(4, 99, "unmask_irq");

    // PRESET change during CNT does not affect the running count
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h9);
    repeat (2) cyc();
    wr(2'd1, 32'd50);
    rd(2'd2, 32'd3, "preset_mid_count");
    for (int k = 4; k <= 8; k++) begin
      cyc();
      chk("preset_mid_irq", {31'd0, bus.irq}, (k >= 7) ? 32'd1 : 32'd0);
    end
    rd(2'd1, 32'd50, "preset_readback");
    wr(2'd0, 32'h0);

    // PRESET=0 reaches INT 3 edges after enable
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    irq_rise(5, 3, "p0_irq");
    wr(2'd0, 32'h0);

    // CPU CTRL write on the INT edge wins over the one-shot EN clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    repeat (4) cyc();
    chk("int_edge_pre_irq", {31'd0, bus.irq}, 32'd1);
    wr(2'd0, 32'h9);
    chk("int_edge_irq_cleared", {31'd0, bus.irq}, 32'd0);
    rd(2'd0, 32'h9, "int_edge_ctrl_en_kept");
    irq_rise(5, 4, "int_edge_rerun_irq");
    wr(2'd0, 32'h0);

    // MODE=1 request: auto-reload pulses when built in, else one-shot with MODE read as 0
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
`ifdef TIMER_RELOAD_EN
    for (int k = 1; k <= 18; k++) begin
      cyc();
      chk("reload_irq", {31'd0, bus.irq}, (k == 5 || k == 11 || k == 17) ? 32'd1 : 32'd0);
    end
    rd(2'd0, 32'hB, "reload_ctrl");
`else
    irq_rise(18, 5, "noreload_irq");
    rd(2'd0, 32'h8, "noreload_ctrl");
`endif
    wr(2'd0, 32'h0);

    // Reset in the middle of a count
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h9);
    repeat (4) cyc();
    reset = 1'b1;
    #2;
    rd(2'd0, 32'd0, "midrst_ctrl");
    rd(2'd1, 32'd0, "midrst_preset");
    rd(2'd2, 32'd0, "midrst_count");
    chk("midrst_irq", {31'd0, bus.irq}, 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    irq_rise(20, 99, "postrst_irq");
    rd(2'd2, 32'd0, "postrst_count");
    rd(2'd0, 32'd0, "postrst_ctrl");

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
